buyruk_getir: RTL and testbench

- Instruction fetch stage that sits directly upstream of the single-cycle core.
- Generates sequential fetch addresses and issues one-at-a-time requests to instruction memory over a valid/ready handshake.
- Buffers returned instruction words with their PCs in a small in-order queue and presents the head entry to the core.
- Accepts a redirect (branch/jump target) from the core, which flushes the queue and discards any in-flight response.

---
 rtl/buyruk_getir.sv | 166 ++++++++++++++++
 tb/tb_buyruk_getir.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buyruk_getir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : buyruk_getir                                               |
// | Description : Instruction fetch stage. Issues one word request at a      |
// |               time over a valid/ready handshake, buffers the returned    |
// |               words with their PCs in an in-order queue and presents     |
// |               the head entry to the core. A redirect flushes the queue   |
// |               and discards any in-flight response.                       |
// | Ports       : saat/reset            - clock, async active-high reset     |
// |               bellek_istek/adres    - memory request (registered)        |
// |               bellek_hazir          - memory accepts the request         |
// |               bellek_veri_gecerli/  - in-order memory response           |
// |               bellek_veri                                                |
// |               yonlendir/_ps         - redirect strobe and target         |
// |               buyruk/buyruk_ps      - head word and its PC (0 if empty)  |
// |               buyruk_gecerli        - queue non-empty                    |
// |               buyruk_al             - core consumes the head entry       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module buyruk_getir #(
    parameter int unsigned DERINLIK     = 4,
    parameter logic [31:0] BASLANGIC_PS = 32'h0000_0000
) (
    input  logic        saat,
    input  logic        reset,
    output logic        bellek_istek,
    output logic [31:0] bellek_adres,
    input  logic        bellek_hazir,
    input  logic        bellek_veri_gecerli,
    input  logic [31:0] bellek_veri,
    input  logic        yonlendir,
    input  logic [31:0] yonlendir_ps,
    output logic [31:0] buyruk,
    output logic [31:0] buyruk_ps,
    output logic        buyruk_gecerli,
    input  logic        buyruk_al
);

    localparam int unsigned     c_AW       = $clog2(DERINLIK);
    localparam logic [c_AW:0]   c_DERINLIK = (c_AW + 1)'(DERINLIK);
    localparam logic [c_AW:0]   c_SAY_BIR  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_IS_BIR   = (c_AW)'(1);

    localparam logic [1:0] c_BOSTA = 2'd0;  // no request outstanding
    localparam logic [1:0] c_ISTEK = 2'd1;  // request asserted, waiting for ready
    localparam logic [1:0] c_BEKLE = 2'd2;  // accepted, waiting for the response

    logic [1:0]      r_durum;
    logic [31:0]     r_sonraki_ps;
    logic            r_at;          // drop the next response (set by a redirect)
    logic [c_AW:0]   r_sayac;       // queue occupancy
    logic [c_AW-1:0] r_bas;         // read pointer
    logic [c_AW-1:0] r_kuyruk;      // write pointer
    logic [31:0]     r_kuyruk_veri [DERINLIK];
    logic [31:0]     r_kuyruk_ps   [DERINLIK];

    logic            w_bos;
    logic            w_pop;
    logic            w_push;
    logic            w_bekleyen;
    logic            w_kredi;
    logic [31:0]     w_hedef;

    assign w_bos      = (r_sayac == '0);
    assign w_pop      = !w_bos && buyruk_al;
    // A response is only kept when no redirect is pending or arriving; the
    // redirect flush would otherwise lose the flush or keep a stale word.
    assign w_push     = (r_durum == c_BEKLE) && bellek_veri_gecerli && !r_at && !yonlendir;
    assign w_bekleyen = (r_durum != c_BOSTA);
    // Occupancy plus the (at most one) outstanding request must leave room,
    // so a returning word can always be pushed without a full check.
    assign w_kredi    = ((r_sayac + (c_AW + 1)'(w_bekleyen)) < c_DERINLIK);
    assign w_hedef    = yonlendir_ps & 32'hFFFF_FFFC;

    assign buyruk_gecerli = !w_bos;
    assign buyruk         = w_bos ? 32'h0 : r_kuyruk_veri[r_bas];
    assign buyruk_ps      = w_bos ? 32'h0 : r_kuyruk_ps[r_bas];

    // Request state machine
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_durum      <= c_BOSTA;
            r_sonraki_ps <= BASLANGIC_PS;
            r_at         <= 1'b0;
            bellek_istek <= 1'b0;
            bellek_adres <= BASLANGIC_PS;
        end else begin
            if (yonlendir) begin
                r_sonraki_ps <= w_hedef;
            end
            case (r_durum)
                c_BOSTA: begin
                    if (w_kredi && !yonlendir) begin
                        r_durum      <= c_ISTEK;
                        bellek_istek <= 1'b1;
                        bellek_adres <= r_sonraki_ps;
                    end
                end
                c_ISTEK: begin
                    // The request is never withdrawn; a redirect only marks
                    // its eventual response for dropping.
                    if (yonlendir) begin
                        r_at <= 1'b1;
                    end
                    if (bellek_hazir) begin
                        r_durum      <= c_BEKLE;
                        bellek_istek <= 1'b0;
                        // Once redirected, next-fetch PC already holds the
                        // target and must not be advanced past it.
                        if (!yonlendir && !r_at) begin
                            r_sonraki_ps <= r_sonraki_ps + 32'd4;
                        end
                    end
                end
                c_BEKLE: begin
                    if (bellek_veri_gecerli) begin
                        r_at    <= 1'b0;
                        r_durum <= c_BOSTA;
                    end else if (yonlendir) begin
                        r_at <= 1'b1;
                    end
                end
                default: begin
                    r_durum      <= c_BOSTA;
                    bellek_istek <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_sayac  <= '0;
            r_bas    <= '0;
            r_kuyruk <= '0;
        end else if (yonlendir) begin
            r_sayac  <= '0;
            r_bas    <= '0;
            r_kuyruk <= '0;
        end else begin
            if (w_push) begin
                r_kuyruk <= r_kuyruk + c_IS_BIR;
            end
            if (w_pop) begin
                r_bas <= r_bas + c_IS_BIR;
            end
            case ({w_push, w_pop})
                2'b10:   r_sayac <= r_sayac + c_SAY_BIR;
                2'b01:   r_sayac <= r_sayac - c_SAY_BIR;
                default: r_sayac <= r_sayac;
            endcase
        end
    end

    // Queue storage; contents are qualified by occupancy, so no reset needed.
    // bellek_adres still holds the PC of the outstanding request here.
    always_ff @(posedge saat) begin
        if (w_push) begin
            r_kuyruk_veri[r_kuyruk] <= bellek_veri;
            r_kuyruk_ps[r_kuyruk]   <= bellek_adres;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buyruk_getir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_buyruk_getir                                            |
// | Description : Self-checking bench for buyruk_getir with a memory model   |
// |               and an expected-word scoreboard.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_buyruk_getir;

    localparam logic [31:0] c_BASLANGIC = 32'h0000_0000;
    localparam logic [31:0] c_DESEN     = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] ps;
        logic [31:0] veri;
    } beklenen_t;

    logic        saat;
    logic        reset;
    logic        bellek_istek;
    logic [31:0] bellek_adres;
    logic        bellek_hazir;
    logic        bellek_veri_gecerli;
    logic [31:0] bellek_veri;
    logic        yonlendir;
    logic [31:0] yonlendir_ps;
    logic [31:0] buyruk;
    logic [31:0] buyruk_ps;
    logic        buyruk_gecerli;
    logic        buyruk_al;

    buyruk_getir #(
        .DERINLIK     (4),
        .BASLANGIC_PS (c_BASLANGIC)
    ) u_dut (
        .saat                (saat),
        .reset               (reset),
        .bellek_istek        (bellek_istek),
        .bellek_adres        (bellek_adres),
        .bellek_hazir        (bellek_hazir),
        .bellek_veri_gecerli (bellek_veri_gecerli),
        .bellek_veri         (bellek_veri),
        .yonlendir           (yonlendir),
        .yonlendir_ps        (yonlendir_ps),
        .buyruk              (buyruk),
        .buyruk_ps           (buyruk_ps),
        .buyruk_gecerli      (buyruk_gecerli),
        .buyruk_al           (buyruk_al)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    int n_chk  = 0;
    int n_pass = 0;

    // stimulus knobs
    logic        tb_hazir, tb_al, tb_yon;
    logic [31:0] tb_yon_ps;
    int          tb_gecikme;

    // memory model
    logic        mem_bekliyor;
    logic [31:0] mem_adres;
    int          mem_sayac;

    // fetch model and scoreboard
    beklenen_t   bekl[$];
    logic [31:0] kabul_q[$];
    int          kabul_cyc_q[$];
    logic [31:0] tb_sonraki, istek_kayit, son_ps;
    logic        tb_at, onceki_istek, ilk_gecerli_gorundu;
    int          cyc, istek_sure, son_istek_sure, ilk_gecerli_cyc, pop_say;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        n_chk++;
        if (gozlenen === beklenen) n_pass++;
        else $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    endtask

    task automatic model_sifirla();
        bekl.delete();
        kabul_q.delete();
        kabul_cyc_q.delete();
        mem_bekliyor        = 1'b0;
        mem_adres           = '0;
        mem_sayac           = 0;
        tb_sonraki          = c_BASLANGIC;
        tb_at               = 1'b0;
        onceki_istek        = 1'b0;
        ilk_gecerli_gorundu = 1'b0;
        ilk_gecerli_cyc     = 0;
        istek_sure          = 0;
        son_istek_sure      = 0;
        pop_say             = 0;
        son_ps              = '0;
    endtask

    task automatic sifirla();
        @(negedge saat);
        reset               = 1'b1;
        bellek_hazir        = 1'b0;
        bellek_veri_gecerli = 1'b0;
        bellek_veri         = '0;
        yonlendir           = 1'b0;
        yonlendir_ps        = '0;
        buyruk_al           = 1'b0;
        tb_yon              = 1'b0;
        model_sifirla();
        @(posedge saat);
        @(negedge saat);
        reset = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge must do.
    task automatic adim();
        logic      kabul;
        logic      yanit;
        beklenen_t e;
        @(negedge saat);
        bellek_veri_gecerli = mem_bekliyor && (mem_sayac == 0);
        bellek_veri         = bellek_veri_gecerli ? (mem_adres ^ c_DESEN) : 32'hDEAD_BEEF;
        bellek_hazir        = tb_hazir;
        buyruk_al           = tb_al;
        yonlendir           = tb_yon;
        yonlendir_ps        = tb_yon_ps;
        #1;
        cyc++;
        yanit = bellek_veri_gecerli;
        kabul = bellek_istek && bellek_hazir;

        if (bellek_istek) begin
            if (!onceki_istek) begin
                kontrol("istek_adres", bellek_adres, tb_sonraki);
                istek_kayit = bellek_adres;
                istek_sure  = 0;
            end else begin
                kontrol("istek_sabit", bellek_adres, istek_kayit);
            end
            istek_sure++;
        end

        if (buyruk_gecerli && !ilk_gecerli_gorundu) begin
            ilk_gecerli_gorundu = 1'b1;
            ilk_gecerli_cyc     = cyc;
        end

        if (!buyruk_gecerli) begin
            kontrol("bos_buyruk", buyruk, 32'h0);
            kontrol("bos_ps", buyruk_ps, 32'h0);
        end else if (buyruk_al) begin
            if (bekl.size() == 0) begin
                kontrol("sb_bos", 32'(bekl.size()), 32'd1);
            end else begin
                e = bekl.pop_front();
                kontrol("buyruk_ps", buyruk_ps, e.ps);
                kontrol("buyruk", buyruk, e.veri);
                son_ps = buyruk_ps;
                pop_say++;
            end
        end

        if (yanit) mem_bekliyor = 1'b0;
        else if (mem_bekliyor) mem_sayac--;

        if (kabul) begin
            mem_bekliyor = 1'b1;
            mem_adres    = bellek_adres;
            mem_sayac    = tb_gecikme;
            kabul_q.push_back(bellek_adres);
            kabul_cyc_q.push_back(cyc);
            son_istek_sure = istek_sure;
            if (!tb_at) bekl.push_back({bellek_adres, bellek_adres ^ c_DESEN});
            if (!yonlendir && !tb_at) tb_sonraki = bellek_adres + 32'd4;
            tb_at = 1'b0;
        end
        if (yonlendir) begin
            bekl.delete();
            if (bellek_istek && !kabul) tb_at = 1'b1;
            tb_sonraki = yonlendir_ps & 32'hFFFF_FFFC;
        end
        onceki_istek = bellek_istek && !kabul;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: gozlenen=timeout beklenen=finish");
        $fatal(1);
    end

    initial begin
        int n0;
        cyc        = 0;
        tb_hazir   = 1'b0;
        tb_al      = 1'b0;
        tb_yon     = 1'b0;
        tb_yon_ps  = '0;
        tb_gecikme = 0;
        reset      = 1'b0;

        // 1: reset values, sequential fetch, always-consuming core
        sifirla();
        #1;
        kontrol("rst_istek", bellek_istek, 1'b0);
        kontrol("rst_adres", bellek_adres, c_BASLANGIC);
        kontrol("rst_gecerli", buyruk_gecerli, 1'b0);
        kontrol("rst_buyruk", buyruk, 32'h0);
        kontrol("rst_ps", buyruk_ps, 32'h0);
        tb_hazir = 1'b1;
        tb_al    = 1'b1;
        for (int i = 0; i < 14; i++) adim();
        kontrol("t1_kabul_say", 32'(kabul_q.size() >= 4), 32'd1);
        if (kabul_q.size() >= 4) begin
            kontrol("t1_adr0", kabul_q[0], 32'h0);
            kontrol("t1_adr1", kabul_q[1], 32'h4);
            kontrol("t1_adr2", kabul_q[2], 32'h8);
            kontrol("t1_adr3", kabul_q[3], 32'hC);
            kontrol("t1_aralik", 32'(kabul_cyc_q[2] - kabul_cyc_q[1]), 32'd3);
            kontrol("t1_ilk_gecerli", 32'(ilk_gecerli_cyc - kabul_cyc_q[0]), 32'd2);
        end

        // 2: core stalled, queue fills, single pop frees one credit
        sifirla();
        tb_hazir = 1'b1;
        tb_al    = 1'b0;
        for (int i = 0; i < 20; i++) adim();
        kontrol("t2_dolu_say", 32'(kabul_q.size()), 32'd4);
        kontrol("t2_istek_yok", bellek_istek, 1'b0);
        kontrol("t2_gecerli", buyruk_gecerli, 1'b1);
        tb_al = 1'b1;
        adim();
        tb_al = 1'b0;
        for (int i = 0; i < 10; i++) adim();
        kontrol("t2_tek_istek", 32'(kabul_q.size()), 32'd5);
        if (kabul_q.size() >= 5) kontrol("t2_adr16", kabul_q[4], 32'h10);

        // 3: memory not ready for 5 cycles
        sifirla();
        tb_hazir = 1'b0;
        tb_al    = 1'b1;
        for (int i = 0; i < 5; i++) adim();
        kontrol("t3_kabul_yok", 32'(kabul_q.size()), 32'd0);
        tb_hazir = 1'b1;
        adim();
        kontrol("t3_kabul", 32'(kabul_q.size()), 32'd1);
        kontrol("t3_sure", 32'(son_istek_sure), 32'd6);
        for (int i = 0; i < 4; i++) adim();

        // 4: redirect while waiting for the address-8 response
        sifirla();
        tb_hazir   = 1'b1;
        tb_al      = 1'b0;
        tb_gecikme = 1;
        for (int i = 0; i < 40 && kabul_q.size() < 3; i++) adim();
        kontrol("t4_bekle", 32'(kabul_q.size()), 32'd3);
        kontrol("t4_dolu", buyruk_gecerli, 1'b1);
        tb_yon    = 1'b1;
        tb_yon_ps = 32'h0000_0103;
        adim();
        tb_yon = 1'b0;
        adim();
        kontrol("t4_bosaldi", buyruk_gecerli, 1'b0);
        tb_al = 1'b1;
        n0    = pop_say;
        for (int i = 0; i < 30 && pop_say == n0; i++) adim();
        kontrol("t4_pop_ps", son_ps, 32'h0000_0100);
        if (kabul_q.size() >= 4) kontrol("t4_adr", kabul_q[3], 32'h0000_0100);
        tb_gecikme = 0;
        for (int i = 0; i < 8; i++) adim();

        // 5: redirect coincides with a response; wrap at the top of memory
        sifirla();
        tb_hazir = 1'b1;
        tb_al    = 1'b1;
        for (int i = 0; i < 40 && kabul_q.size() < 2; i++) adim();
        kontrol("t5_bekle", 32'(kabul_q.size()), 32'd2);
        tb_yon    = 1'b1;
        tb_yon_ps = 32'hFFFF_FFFC;
        adim();
        tb_yon = 1'b0;
        n0     = pop_say;
        for (int i = 0; i < 40 && kabul_q.size() < 4; i++) adim();
        for (int i = 0; i < 10 && pop_say == n0; i++) adim();
        kontrol("t5_pop_ps", son_ps, 32'hFFFF_FFFC);
        if (kabul_q.size() >= 4) begin
            kontrol("t5_adr_ust", kabul_q[2], 32'hFFFF_FFFC);
            kontrol("t5_adr_sar", kabul_q[3], 32'h0);
        end
        for (int i = 0; i < 6; i++) adim();

        // 6: asynchronous reset in the middle of a response wait
        sifirla();
        tb_hazir   = 1'b1;
        tb_al      = 1'b0;
        tb_gecikme = 2;
        for (int i = 0; i < 40 && kabul_q.size() < 2; i++) adim();
        kontrol("t6_bekle", 32'(kabul_q.size()), 32'd2);
        kontrol("t6_dolu", buyruk_gecerli, 1'b1);
        @(posedge saat);
        #3;
        reset = 1'b1;
        #1;
        kontrol("t6_istek", bellek_istek, 1'b0);
        kontrol("t6_adres", bellek_adres, c_BASLANGIC);
        kontrol("t6_gecerli", buyruk_gecerli, 1'b0);
        kontrol("t6_buyruk", buyruk, 32'h0);
        kontrol("t6_ps", buyruk_ps, 32'h0);
        model_sifirla();
        bellek_veri_gecerli = 1'b0;
        @(posedge saat);
        @(negedge saat);
        reset      = 1'b0;
        tb_gecikme = 0;
        tb_al      = 1'b1;
        for (int i = 0; i < 20 && kabul_q.size() < 1; i++) adim();
        if (kabul_q.size() >= 1) kontrol("t6_ilk_adr", kabul_q[0], c_BASLANGIC);
        else kontrol("t6_ilk_kabul", 32'(kabul_q.size()), 32'd1);
        for (int i = 0; i < 6; i++) adim();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
